// File: rtl/stage_if.sv
// Instruction-fetch stage: program counter, direct-mapped one-word-per-line I-cache,
// and a registered req/ready miss fetch that can be dropped by a redirect while in flight.
module stage_if #(
    parameter int ICACHE_LINES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        discard,
    input  logic [31:0] jump_target,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        stall_req,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data
);
    // state | meaning
    // IDLE  | look up pc in the cache; a miss issues a fetch
    // WAIT  | fetch of mem_addr outstanding; drop set means its word is not presented
    typedef enum logic {IDLE, WAIT} state_t;

    localparam int IDX  = $clog2(ICACHE_LINES);
    localparam int TAGW = 32 - IDX - 2;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_pc;
    logic [31:0]        w_pc_nxt;
    logic               r_drop;
    logic               w_drop_nxt;
    logic               r_mem_req;
    logic               w_mem_req_nxt;
    logic [31:0]        r_mem_addr;
    logic [31:0]        w_mem_addr_nxt;

    logic [ICACHE_LINES-1:0] r_valid;
    logic [TAGW-1:0]         r_tag  [ICACHE_LINES];
    logic [31:0]             r_data [ICACHE_LINES];

    logic [IDX-1:0] w_idx;
    logic [IDX-1:0] w_fill_idx;
    logic           w_hit;
    logic           w_fill;
    logic           w_valid;

    assign w_idx      = r_pc[IDX+1:2];
    assign w_fill_idx = r_mem_addr[IDX+1:2];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == r_pc[31:IDX+2]);
    assign w_fill     = (r_state == WAIT) && mem_ready;
    assign w_valid    = ((r_state == IDLE) && w_hit) || (w_fill && !r_drop);

    always_comb begin
        pc_o      = r_pc;
        stall_req = !w_valid;
        inst_o    = '0;
        if ((r_state == IDLE) && w_hit) begin
            inst_o = r_data[w_idx];
        end else if (w_fill && !r_drop && !discard) begin
            inst_o = mem_data;
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;

    always_comb begin
        w_state_nxt    = r_state;
        w_drop_nxt     = r_drop;
        w_mem_req_nxt  = r_mem_req;
        w_mem_addr_nxt = r_mem_addr;
        w_pc_nxt       = r_pc;

        if (discard) begin
            w_pc_nxt = jump_target & ~32'd3;
        end else if (w_valid && !stall) begin
            w_pc_nxt = r_pc + 32'd4;
        end

        case (r_state)
            IDLE: begin
                // A redirect in the same cycle makes this pc dead, so never fetch it.
                if (!w_hit && !discard) begin
                    w_state_nxt    = WAIT;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = r_pc;
                    w_drop_nxt     = 1'b0;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    w_state_nxt   = IDLE;
                    w_mem_req_nxt = 1'b0;
                    w_drop_nxt    = 1'b0;
                end else if (discard) begin
                    w_drop_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_drop     <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_valid    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_drop     <= w_drop_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Fill is keyed on mem_addr so a dropped fetch still lands in the right line.
    always_ff @(posedge clock) begin
        if (w_fill) begin
            r_tag[w_fill_idx]  <= r_mem_addr[31:IDX+2];
            r_data[w_fill_idx] <= mem_data;
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: cycle-exact vector table for the directed corners, then a
// random-latency/random-stall streaming run checked by an instruction scoreboard.
module tb_stage_if;
    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        discard;
    logic [31:0] jump_target;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        stall_req;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;

    logic        auto_mem;
    logic        t_ready;
    logic [31:0] t_data;
    logic        ar_ready;
    logic [31:0] ar_data;
    int          wait_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    assign mem_ready = auto_mem ? ar_ready : t_ready;
    assign mem_data  = auto_mem ? ar_data  : t_data;

    always #5 clock = ~clock;

    stage_if #(.ICACHE_LINES(64)) dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .discard    (discard),
        .jump_target(jump_target),
        .pc_o       (pc_o),
        .inst_o     (inst_o),
        .stall_req  (stall_req),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data)
    );

    typedef struct {
        bit          rst;
        bit          st;
        bit          dc;
        logic [31:0] jt;
        bit          rdy;
        logic [31:0] dat;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        bit          e_sreq;
        bit          e_req;
        logic [31:0] e_addr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input bit rst, input bit st, input bit dc, input logic [31:0] jt,
                       input bit rdy, input logic [31:0] dat, input logic [31:0] pc,
                       input logic [31:0] inst, input bit sreq, input bit req,
                       input logic [31:0] addr);
        vec_t v;
        v.rst = rst; v.st = st; v.dc = dc; v.jt = jt; v.rdy = rdy; v.dat = dat;
        v.e_pc = pc; v.e_inst = inst; v.e_sreq = sreq; v.e_req = req; v.e_addr = addr;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; discard = 1'b0; jump_target = '0;
        t_ready = 1'b0; t_data = '0;
        repeat (2) @(posedge clock);
    endtask

    // Memory model for the streaming run: 1..4 cycle latency, one ready per request.
    initial begin
        ar_ready = 1'b0;
        ar_data  = '0;
        wait_cnt = 0;
        forever begin
            @(posedge clock);
            #1;
            ar_ready = 1'b0;
            if (auto_mem && mem_req) begin
                if (wait_cnt == 0) begin
                    ar_ready = 1'b1;
                    ar_data  = f(mem_addr);
                    wait_cnt = int'($urandom_range(0, 3));
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    initial begin
        int popped;
        bit req_seen;
        exp_t e;
        auto_mem = 1'b0;

        //  rst st dc jt        rdy dat        pc        inst       sreq req addr
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h000, 32'h0,     1, 0, 32'h000); // c0
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h000, 32'h0,     1, 1, 32'h000);
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h000, 32'h0,     1, 1, 32'h000);
        add(0, 0, 0, 32'h0,   1, f(32'h0),  32'h000, f(32'h0),  0, 1, 32'h000);
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h004, 32'h0,     1, 0, 32'h000);
        add(0, 0, 0, 32'h0,   1, f(32'h4),  32'h004, f(32'h4),  0, 1, 32'h004);
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h008, 32'h0,     1, 0, 32'h000);
        add(0, 0, 0, 32'h0,   1, f(32'h8),  32'h008, f(32'h8),  0, 1, 32'h008);
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h00C, 32'h0,     1, 0, 32'h000);
        add(0, 0, 0, 32'h0,   1, f(32'hC),  32'h00C, f(32'hC),  0, 1, 32'h00C);
        add(0, 0, 1, 32'h0,   0, 32'h0,     32'h010, 32'h0,     1, 0, 32'h000); // c10 jump 0
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h000, f(32'h0),  0, 0, 32'h000);
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h004, f(32'h4),  0, 0, 32'h000);
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h008, f(32'h8),  0, 0, 32'h000);
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h00C, f(32'hC),  0, 0, 32'h000);
        add(0, 0, 1, 32'h23,  0, 32'h0,     32'h010, 32'h0,     1, 0, 32'h000); // c15
        add(0, 0, 0, 32'h0,   1, 32'hBAD,   32'h020, 32'h0,     1, 0, 32'h000); // ready in IDLE
        add(0, 0, 1, 32'h103, 0, 32'h0,     32'h020, 32'h0,     1, 1, 32'h020);
        add(0, 0, 0, 32'h0,   1, f(32'h20), 32'h100, 32'h0,     1, 1, 32'h020); // dropped fill
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h100, 32'h0,     1, 0, 32'h000);
        add(0, 0, 0, 32'h0,   1, f(32'h100),32'h100, f(32'h100),0, 1, 32'h100); // c20 evicts 0
        add(0, 0, 1, 32'h20,  0, 32'h0,     32'h104, 32'h0,     1, 0, 32'h000);
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h020, f(32'h20), 0, 0, 32'h000);
        add(0, 0, 1, 32'h0,   0, 32'h0,     32'h024, 32'h0,     1, 0, 32'h000);
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h000, 32'h0,     1, 0, 32'h000); // 0 misses again
        add(0, 1, 0, 32'h0,   1, f(32'h0),  32'h000, f(32'h0),  0, 1, 32'h000); // c25 stalled fill
        add(0, 1, 0, 32'h0,   0, 32'h0,     32'h000, f(32'h0),  0, 0, 32'h000);
        add(0, 1, 0, 32'h0,   0, 32'h0,     32'h000, f(32'h0),  0, 0, 32'h000);
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h000, f(32'h0),  0, 0, 32'h000);
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h004, f(32'h4),  0, 0, 32'h000);
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h008, f(32'h8),  0, 0, 32'h000); // c30
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h00C, f(32'hC),  0, 0, 32'h000);
        add(0, 1, 0, 32'h0,   0, 32'h0,     32'h010, 32'h0,     1, 0, 32'h000);
        add(0, 1, 0, 32'h0,   0, 32'h0,     32'h010, 32'h0,     1, 1, 32'h010);
        add(0, 1, 0, 32'h0,   1, f(32'h10), 32'h010, f(32'h10), 0, 1, 32'h010);
        add(0, 1, 0, 32'h0,   0, 32'h0,     32'h010, f(32'h10), 0, 0, 32'h000);
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h010, f(32'h10), 0, 0, 32'h000);
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h014, 32'h0,     1, 0, 32'h000);
        add(1, 0, 0, 32'h0,   0, 32'h0,     32'h014, 32'h0,     1, 1, 32'h014); // reset in WAIT
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h000, 32'h0,     1, 0, 32'h000);
        add(0, 0, 0, 32'h0,   0, 32'h0,     32'h000, 32'h0,     1, 1, 32'h000); // c40

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clock);
            #1;
            reset       = vecs[i].rst;
            stall       = vecs[i].st;
            discard     = vecs[i].dc;
            jump_target = vecs[i].jt;
            t_ready     = vecs[i].rdy;
            t_data      = vecs[i].dat;
            #2;
            chk($sformatf("vec%0d pc_o", i), pc_o, vecs[i].e_pc);
            chk($sformatf("vec%0d inst_o", i), inst_o, vecs[i].e_inst);
            chk($sformatf("vec%0d stall_req", i), {31'b0, stall_req}, {31'b0, vecs[i].e_sreq});
            chk($sformatf("vec%0d mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].e_req});
            if (vecs[i].e_req) chk($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].e_addr);
        end

        // Streaming: 0x000..0x0FC from memory, jump back, then the same 64 words as hits.
        do_reset();
        auto_mem = 1'b1;
        for (int a = 0; a < 256; a += 4) begin
            e.pc = a; e.inst = f(a); sb.push_back(e);
        end
        popped   = 0;
        req_seen = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int cyc = 0; cyc < 3000 && popped < 64 * (pass + 1); cyc++) begin
                @(posedge clock);
                #1;
                reset   = 1'b0;
                discard = 1'b0;
                stall   = ($urandom_range(0, 3) == 0);
                #2;
                if (pass == 1 && mem_req) req_seen = 1'b1;
                if (!stall_req && !stall) begin
                    if (sb.size() == 0) begin
                        chk("sb unexpected instr pc", pc_o, 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("sb pc_o", pc_o, e.pc);
                        chk("sb inst_o", inst_o, e.inst);
                        popped++;
                    end
                end
            end
            chk($sformatf("pass%0d instr count", pass), popped, 64 * (pass + 1));
            if (pass == 0) begin
                @(posedge clock);
                #1;
                stall = 1'b0; discard = 1'b1; jump_target = 32'h0;
                #2;
                chk("wrap pc_o", pc_o, 32'h100);
                chk("wrap stall_req", {31'b0, stall_req}, 32'd1);
                for (int a = 0; a < 256; a += 4) begin
                    e.pc = a; e.inst = f(a); sb.push_back(e);
                end
            end
        end
        chk("pass1 mem_req seen", {31'b0, req_seen}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
